skew_deskew_buffer: RTL and testbench

- Parametrised triangular skew/deskew register array for the Lego systolic array.
- Skew mode delays lane k by k cycles, feeding wavefront-aligned activations into the array edge.
- Deskew mode delays lane k by N_SIZE-1-k cycles, realigning array outputs into a flat vector.
- Adds per-lane valid, stall, flush, runtime lane masking and frame-end tracking.

---
 rtl/skew_deskew_buffer_if.sv | 23 ++
 rtl/skew_deskew_buffer.sv | 128 ++++++++++++
 tb/tb_skew_deskew_buffer.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/skew_deskew_buffer_if.sv
// Stream bundle for skew_deskew_buffer: input vector with valid/last, delayed lane data out.
// The master drives the input vector; the slave (the buffer) drives the delayed outputs.
interface skew_deskew_buffer_if #(
    parameter int DATAWIDTH = 8,
    parameter int N_SIZE    = 16
);
    logic                                in_valid;
    logic                                in_last;
    logic [N_SIZE-1:0][DATAWIDTH-1:0]    act_in;
    logic [N_SIZE-1:0][DATAWIDTH-1:0]    act_out;
    logic [N_SIZE-1:0]                   out_valid;
    logic                                out_last;

    modport master (
        output in_valid, in_last, act_in,
        input  act_out, out_valid, out_last
    );

    modport slave (
        input  in_valid, in_last, act_in,
        output act_out, out_valid, out_last
    );
endinterface

// File: rtl/skew_deskew_buffer.sv
// Triangular skew/deskew register array: lane k is delayed by k (skew) or N_SIZE-1-k (deskew)
// cycles, with per-lane valid, stall, flush, runtime lane masking and frame-end tracking.
module skew_deskew_buffer #(
    parameter int DATAWIDTH = 8,
    parameter int N_SIZE    = 16,
    parameter int LW        = $clog2(N_SIZE + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 flush,
    input  logic                 cfg_we,
    input  logic                 cfg_mode,
    input  logic [LW-1:0]        cfg_lanes,
    skew_deskew_buffer_if.slave  bus,
    output logic                 busy,
    output logic                 cfg_err
);

    localparam int DEPTH = N_SIZE - 1;

    typedef enum logic {
        MODE_SKEW   = 1'b0,
        MODE_DESKEW = 1'b1
    } mode_e;

    mode_e                             mode_q;
    logic [LW-1:0]                     lanes_q;
    logic [DEPTH-1:0]                  last_q;
    logic [N_SIZE-1:0]                 lane_busy;
    logic [N_SIZE-1:0][DATAWIDTH-1:0]  out_data;
    logic [N_SIZE-1:0]                 out_vld;
    logic                              accept;
    logic                              cfg_ok;
    logic [LW-1:0]                     cfg_lanes_fixed;

    assign accept = bus.in_valid & en;

    for (genvar k = 0; k < N_SIZE; k++) begin : g_lane
        // Each chain only needs to reach the deeper of its two taps. Lane 0 always keeps the
        // full N_SIZE-1 length and is never masked, so busy is unchanged by the trimming.
        localparam int LEN = (k > N_SIZE - 1 - k) ? k : N_SIZE - 1 - k;

        logic                          lane_on;
        logic [DATAWIDTH-1:0]          in_d;
        logic                          in_v;
        logic [LEN-1:0][DATAWIDTH-1:0] dq;
        logic [LEN-1:0]                vq;
        logic [DATAWIDTH-1:0]          skew_d;
        logic [DATAWIDTH-1:0]          desk_d;
        logic                          skew_v;
        logic                          desk_v;

        assign lane_on = (LW'(k) < lanes_q);
        assign in_d    = lane_on ? bus.act_in[k] : '0;
        assign in_v    = lane_on & bus.in_valid;

        always_ff @(posedge clk) begin
            if (rst || flush) begin
                dq <= '0;
                vq <= '0;
            end else if (en) begin
                dq[0] <= in_d;
                vq[0] <= in_v;
                for (int unsigned d = 1; d < LEN; d++) begin
                    dq[d] <= dq[d-1];
                    vq[d] <= vq[d-1];
                end
            end
        end

        if (k == 0) begin : g_skew_pass
            assign skew_d = in_d;
            assign skew_v = in_v & en;
        end else begin : g_skew_tap
            assign skew_d = dq[k-1];
            assign skew_v = vq[k-1];
        end

        if (k == N_SIZE - 1) begin : g_desk_pass
            assign desk_d = in_d;
            assign desk_v = in_v & en;
        end else begin : g_desk_tap
            assign desk_d = dq[N_SIZE-2-k];
            assign desk_v = vq[N_SIZE-2-k];
        end

        assign out_data[k]  = !lane_on ? '0
                            : (mode_q == MODE_DESKEW) ? desk_d : skew_d;
        assign out_vld[k]   = lane_on & ((mode_q == MODE_DESKEW) ? desk_v : skew_v);
        assign lane_busy[k] = |vq;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            last_q <= '0;
        end else if (en) begin
            last_q[0] <= accept & bus.in_last;
            for (int unsigned d = 1; d < DEPTH; d++) begin
                last_q[d] <= last_q[d-1];
            end
        end
    end

    assign bus.act_out   = out_data;
    assign bus.out_valid = out_vld;
    assign bus.out_last  = last_q[DEPTH-1];
    assign busy          = (|lane_busy) | (|last_q);

    // A flush in the same cycle empties the pipeline, so it also makes the write safe.
    assign cfg_ok          = flush | (~busy & ~accept);
    assign cfg_lanes_fixed = (cfg_lanes == '0 || cfg_lanes > LW'(N_SIZE)) ? LW'(N_SIZE) : cfg_lanes;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q  <= MODE_SKEW;
            lanes_q <= LW'(N_SIZE);
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we & ~cfg_ok;
            if (cfg_we && cfg_ok) begin
                mode_q  <= mode_e'(cfg_mode);
                lanes_q <= cfg_lanes_fixed;
            end
        end
    end

endmodule

// File: tb/tb_skew_deskew_buffer.sv
// Directed bench for skew_deskew_buffer (N_SIZE=4, DATAWIDTH=8): skew/deskew timing, stall,
// lane masking, config accept/reject, flush, mid-flight reset and back-to-back frame ends.
module tb_skew_deskew_buffer;

    logic       clk;
    logic       rst;
    logic       en;
    logic       flush;
    logic       cfg_we;
    logic       cfg_mode;
    logic [2:0] cfg_lanes;
    logic       busy;
    logic       cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    skew_deskew_buffer_if #(.DATAWIDTH(8), .N_SIZE(4)) bus ();

    skew_deskew_buffer #(.DATAWIDTH(8), .N_SIZE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .flush     (flush),
        .cfg_we    (cfg_we),
        .cfg_mode  (cfg_mode),
        .cfg_lanes (cfg_lanes),
        .bus       (bus),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] vec(input int v);
        logic [31:0] r;
        for (int k = 0; k < 4; k++) r[8*k +: 8] = 8'(64 + 16*v + k);
        return r;
    endfunction

    task automatic drive(input logic v, input logic l, input logic [31:0] d);
        bus.in_valid = v;
        bus.in_last  = l;
        bus.act_in   = d;
    endtask

    // Called at posedge+1 with inputs set; samples mid-cycle, returns at next posedge+1.
    task automatic cycle_check(input string tag, input logic [3:0] ev, input logic [31:0] ed,
                               input logic [31:0] dm, input logic el, input logic eb,
                               input logic ee);
        @(negedge clk);
        check({tag, ".valid"}, 32'(bus.out_valid), 32'(ev));
        check({tag, ".data"},  32'(bus.act_out) & dm, ed);
        check({tag, ".last"},  32'(bus.out_last), 32'(el));
        check({tag, ".busy"},  32'(busy), 32'(eb));
        check({tag, ".cfgerr"}, 32'(cfg_err), 32'(ee));
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic mode, input logic [2:0] lanes, input logic ee,
                             input string tag);
        cfg_we    = 1'b1;
        cfg_mode  = mode;
        cfg_lanes = lanes;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        @(negedge clk);
        check(tag, 32'(cfg_err), 32'(ee));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0]  ev;
        logic [31:0] ed;
        logic [31:0] dm;
        int          v;
        logic        iv;

        rst = 1'b1; en = 1'b1; flush = 1'b0;
        cfg_we = 1'b0; cfg_mode = 1'b0; cfg_lanes = 3'd0;
        drive(1'b0, 1'b0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst.act_out",   32'(bus.act_out), 32'h0);
        check("rst.out_valid", 32'(bus.out_valid), 32'h0);
        check("rst.out_last",  32'(bus.out_last), 32'h0);
        check("rst.busy",      32'(busy), 32'h0);
        check("rst.cfg_err",   32'(cfg_err), 32'h0);
        @(posedge clk);
        #1;

        // Skew: lane k appears k cycles after acceptance, out_last with lane 3.
        for (int c = 0; c <= 4; c++) begin
            if (c == 0) drive(1'b1, 1'b1, 32'h0D0C0B0A);
            else        drive(1'b0, 1'b0, 32'h0);
            ev = (c < 4) ? 4'(1 << c) : 4'b0000;
            ed = (c < 4) ? 32'(10 + c) << (8*c) : 32'h0;
            dm = (c < 4) ? 32'hFF << (8*c) : 32'h0;
            cycle_check($sformatf("skew%0d", c), ev, ed, dm, c == 3, c >= 1 && c <= 3, 1'b0);
        end

        // Deskew: lane k injected at cycle k, all four aligned at cycle 3.
        cfg_write(1'b1, 3'd4, 1'b0, "cfg_deskew.err");
        for (int c = 0; c <= 7; c++) begin
            if (c <= 3) drive(1'b1, 1'b0, 32'(20 + c) << (8*c));
            else        drive(1'b0, 1'b0, 32'h0);
            ev = (c <= 3) ? 4'(4'b1111 << (3 - c)) : 4'(4'b0111 >> (c - 4));
            ed = (c == 3) ? 32'h17161514 : 32'h0;
            dm = (c == 3) ? 32'hFFFFFFFF : 32'h0;
            cycle_check($sformatf("deskew%0d", c), ev, ed, dm, 1'b0, c >= 1 && c <= 6, 1'b0);
        end

        // Lane mask (lanes=2) plus a config write rejected while busy.
        cfg_write(1'b0, 3'd2, 1'b0, "cfg_mask.err");
        drive(1'b1, 1'b0, 32'hFFFFFFFF);
        cycle_check("mask0", 4'b0001, 32'h000000FF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0);
        cfg_we = 1'b1; cfg_mode = 1'b1; cfg_lanes = 3'd4;
        cycle_check("mask1", 4'b0010, 32'h0000FF00, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        cfg_we = 1'b0;
        cycle_check("mask2", 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b1);
        cycle_check("mask3", 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        cycle_check("mask4", 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        // Still skew with 2 lanes: the rejected write changed nothing.
        drive(1'b1, 1'b0, 32'h04030201);
        cycle_check("probe0", 4'b0001, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0);
        cycle_check("probe1", 4'b0010, 32'h00000200, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        cycle_check("probe2", 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        cycle_check("probe3", 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        cycle_check("probe4", 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);

        // cfg_lanes=0 selects all 4 lanes; the stall run below relies on lane 3.
        cfg_write(1'b0, 3'd0, 1'b0, "cfg_lanes0.err");

        // Stall: 5 vectors, en low in cycles 2 and 3; e counts enabled edges so far.
        for (int c = 0; c <= 10; c++) begin
            v  = (c < 2) ? c : (c < 4) ? 2 : c - 2;
            iv = (v <= 4);
            en = !(c == 2 || c == 3);
            drive(iv, iv && v == 4, iv ? vec(v) : 32'h0);
            ev = '0; ed = '0; dm = 32'h000000FF;
            ev[0]   = iv & en;
            ed[7:0] = iv ? 8'(64 + 16*v) : 8'h00;
            for (int k = 1; k < 4; k++) begin
                if (v - k >= 0 && v - k <= 4) begin
                    ev[k]         = 1'b1;
                    ed[8*k +: 8]  = 8'(64 + 16*(v - k) + k);
                    dm[8*k +: 8]  = 8'hFF;
                end
            end
            cycle_check($sformatf("stall%0d", c), ev, ed, dm, v == 7, v >= 1 && v <= 7, 1'b0);
        end
        en = 1'b1;

        // Flush one cycle after an in_last vector; a config write alongside is accepted.
        drive(1'b1, 1'b1, 32'h55555555);
        cycle_check("flush0", 4'b0001, 32'h00000055, 32'h000000FF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0);
        flush = 1'b1;
        cfg_we = 1'b1; cfg_mode = 1'b1; cfg_lanes = 3'd3;
        cycle_check("flush1", 4'b0010, 32'h00005500, 32'h0000FF00, 1'b0, 1'b1, 1'b0);
        flush = 1'b0;
        cfg_we = 1'b0;
        for (int c = 2; c <= 5; c++)
            cycle_check($sformatf("flush%0d", c), 4'b0000, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Deskew with 3 lanes (from the flush-time write), then reset one cycle later.
        drive(1'b1, 1'b1, 32'h04030201);
        cycle_check("rst0", 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 32'h0);
        rst = 1'b1;
        cycle_check("rst1", 4'b0100, 32'h00030000, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
        rst = 1'b0;
        for (int c = 2; c <= 5; c++)
            cycle_check($sformatf("rst%0d", c), 4'b0000, 32'h0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
        // After reset: skew mode and 4 lanes again.
        for (int c = 0; c <= 4; c++) begin
            if (c == 0) drive(1'b1, 1'b0, 32'h04030201);
            else        drive(1'b0, 1'b0, 32'h0);
            ev = (c < 4) ? 4'(1 << c) : 4'b0000;
            ed = (c < 4) ? 32'(c + 1) << (8*c) : 32'h0;
            dm = (c < 4) ? 32'hFF << (8*c) : 32'h0;
            cycle_check($sformatf("postrst%0d", c), ev, ed, dm, 1'b0, c >= 1 && c <= 3, 1'b0);
        end

        // cfg_lanes above N_SIZE selects all lanes; then three back-to-back lasts.
        cfg_write(1'b0, 3'd1, 1'b0, "cfg_lanes1.err");
        cfg_write(1'b0, 3'd7, 1'b0, "cfg_lanes7.err");
        for (int c = 0; c <= 6; c++) begin
            if (c <= 2) drive(1'b1, 1'b1, vec(c));
            else        drive(1'b0, 1'b0, 32'h0);
            case (c)
                0:       ev = 4'b0001;
                1:       ev = 4'b0011;
                2:       ev = 4'b0111;
                3:       ev = 4'b1110;
                4:       ev = 4'b1100;
                5:       ev = 4'b1000;
                default: ev = 4'b0000;
            endcase
            cycle_check($sformatf("b2b%0d", c), ev, 32'h0, 32'h0, c >= 3 && c <= 5,
                        c >= 1 && c <= 5, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
